// File: rtl/regfile_sb.sv
// General-purpose register file: two combinational read ports, one write port,
// hardwired zero register, write-to-read bypass and a per-register busy scoreboard.
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [ADDR_W-1:0] RSaddr_i,
    input  logic [ADDR_W-1:0] RTaddr_i,
    input  logic [ADDR_W-1:0] RDaddr_i,
    input  logic [DATA_W-1:0] RDdata_i,
    input  logic              RegWrite_i,
    input  logic              Rsv_i,
    input  logic [ADDR_W-1:0] RsvAddr_i,
    output logic [DATA_W-1:0] RSdata_o,
    output logic [DATA_W-1:0] RTdata_o,
    output logic              RSbusy_o,
    output logic              RTbusy_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q  [DEPTH];
    logic [DATA_W-1:0] mem_d  [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;

    logic wr_en;
    logic rsv_en;

    assign wr_en  = RegWrite_i && !(ZERO_REG && (RDaddr_i == '0));
    assign rsv_en = Rsv_i && !(ZERO_REG && (RsvAddr_i == '0));

    // Release is applied before reserve so a same-address reserve wins.
    always_comb begin
        mem_d  = mem_q;
        busy_d = busy_q;
        if (wr_en) begin
            mem_d[RDaddr_i] = RDdata_i;
        end
        if (RegWrite_i) begin
            busy_d[RDaddr_i] = 1'b0;
        end
        if (rsv_en) begin
            busy_d[RsvAddr_i] = 1'b1;
        end
        if (ZERO_REG) begin
            mem_d[0]  = '0;
            busy_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
        end
    end

    function automatic logic [DATA_W-1:0] read_data(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] val;
        if (ZERO_REG && (addr == '0)) begin
            val = '0;
        end else if (RegWrite_i && (RDaddr_i == addr)) begin
            val = RDdata_i;
        end else begin
            val = mem_q[addr];
        end
        return val;
    endfunction

    // A same-cycle release is visible; a same-cycle reserve is not.
    function automatic logic read_busy(input logic [ADDR_W-1:0] addr);
        logic val;
        if (ZERO_REG && (addr == '0)) begin
            val = 1'b0;
        end else if (RegWrite_i && (RDaddr_i == addr) &&
                     !(Rsv_i && (RsvAddr_i == addr))) begin
            val = 1'b0;
        end else begin
            val = busy_q[addr];
        end
        return val;
    endfunction

    always_comb begin
        RSdata_o = read_data(RSaddr_i);
        RTdata_o = read_data(RTaddr_i);
        RSbusy_o = read_busy(RSaddr_i);
        RTbusy_o = read_busy(RTaddr_i);
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: reset, write/bypass, zero register,
// scoreboard reserve/release interplay and asynchronous reset mid-stream.
module tb_regfile_sb;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [4:0]  RSaddr_i, RTaddr_i, RDaddr_i, RsvAddr_i;
    logic [31:0] RDdata_i;
    logic        RegWrite_i, Rsv_i;
    logic [31:0] RSdata_o, RTdata_o;
    logic        RSbusy_o, RTbusy_o;

    int n_pass  = 0;
    int n_total = 0;

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1)) dut (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .RSaddr_i   (RSaddr_i),
        .RTaddr_i   (RTaddr_i),
        .RDaddr_i   (RDaddr_i),
        .RDdata_i   (RDdata_i),
        .RegWrite_i (RegWrite_i),
        .Rsv_i      (Rsv_i),
        .RsvAddr_i  (RsvAddr_i),
        .RSdata_o   (RSdata_o),
        .RTdata_o   (RTdata_o),
        .RSbusy_o   (RSbusy_o),
        .RTbusy_o   (RTbusy_o)
    );

    always #5 clk_i = ~clk_i;

    // Inputs change on the falling edge; outputs are checked 1 time unit later.
    task automatic idle_inputs();
        RegWrite_i = 1'b0;
        Rsv_i      = 1'b0;
        RDaddr_i   = '0;
        RDdata_i   = '0;
        RsvAddr_i  = '0;
    endtask

    task automatic test_reset();
        rst_n_i  = 1'b1;
        idle_inputs();
        RSaddr_i = 5'd0;
        RTaddr_i = 5'd7;
        @(negedge clk_i);
        #1 rst_n_i = 1'b0;
        #1;
        n_total++;
        if (RSdata_o !== 32'h0) $display("FAIL reset_rs0_data got=%h exp=%h", RSdata_o, 32'h0); else n_pass++;
        n_total++;
        if (RTdata_o !== 32'h0) $display("FAIL reset_rt7_data got=%h exp=%h", RTdata_o, 32'h0); else n_pass++;
        n_total++;
        if ({RSbusy_o, RTbusy_o} !== 2'b00) $display("FAIL reset_busy_0_7 got=%b exp=00", {RSbusy_o, RTbusy_o}); else n_pass++;
        RSaddr_i = 5'd31;
        RTaddr_i = 5'd31;
        #1;
        n_total++;
        if (RSdata_o !== 32'h0 || RTdata_o !== 32'h0)
            $display("FAIL reset_r31_data got=%h/%h exp=0", RSdata_o, RTdata_o);
        else n_pass++;
        n_total++;
        if ({RSbusy_o, RTbusy_o} !== 2'b00) $display("FAIL reset_busy_31 got=%b exp=00", {RSbusy_o, RTbusy_o}); else n_pass++;
        #1 rst_n_i = 1'b1;
    endtask

    task automatic test_write_read();
        @(negedge clk_i);
        RegWrite_i = 1'b1; RDaddr_i = 5'd5; RDdata_i = 32'hDEADBEEF;
        RSaddr_i = 5'd5; RTaddr_i = 5'd6;
        #1;
        n_total++;
        if (RSdata_o !== 32'hDEADBEEF) $display("FAIL wr_bypass got=%h exp=%h", RSdata_o, 32'hDEADBEEF); else n_pass++;
        n_total++;
        if (RTdata_o !== 32'h0) $display("FAIL wr_other_port got=%h exp=%h", RTdata_o, 32'h0); else n_pass++;
        @(negedge clk_i);
        idle_inputs();
        RTaddr_i = 5'd5; RSaddr_i = 5'd6;
        #1;
        n_total++;
        if (RTdata_o !== 32'hDEADBEEF) $display("FAIL wr_stored got=%h exp=%h", RTdata_o, 32'hDEADBEEF); else n_pass++;
        n_total++;
        if (RSdata_o !== 32'h0) $display("FAIL wr_neighbour got=%h exp=%h", RSdata_o, 32'h0); else n_pass++;
    endtask

    task automatic test_zero_reg();
        @(negedge clk_i);
        RegWrite_i = 1'b1; RDaddr_i = 5'd0; RDdata_i = 32'h12345678;
        RSaddr_i = 5'd0;
        #1;
        n_total++;
        if (RSdata_o !== 32'h0) $display("FAIL zero_bypass got=%h exp=%h", RSdata_o, 32'h0); else n_pass++;
        @(negedge clk_i);
        idle_inputs();
        Rsv_i = 1'b1; RsvAddr_i = 5'd0;
        #1;
        n_total++;
        if (RSdata_o !== 32'h0) $display("FAIL zero_stored got=%h exp=%h", RSdata_o, 32'h0); else n_pass++;
        @(negedge clk_i);
        idle_inputs();
        #1;
        n_total++;
        if (RSbusy_o !== 1'b0) $display("FAIL zero_busy got=%b exp=0", RSbusy_o); else n_pass++;
    endtask

    task automatic test_scoreboard();
        @(negedge clk_i);
        Rsv_i = 1'b1; RsvAddr_i = 5'd9; RSaddr_i = 5'd9;
        #1;
        n_total++;
        if (RSbusy_o !== 1'b0) $display("FAIL rsv_no_bypass got=%b exp=0", RSbusy_o); else n_pass++;
        @(negedge clk_i);
        idle_inputs();
        #1;
        n_total++;
        if (RSbusy_o !== 1'b1) $display("FAIL rsv_busy got=%b exp=1", RSbusy_o); else n_pass++;
        @(negedge clk_i);
        RegWrite_i = 1'b1; RDaddr_i = 5'd9; RDdata_i = 32'h0000_00A5;
        #1;
        n_total++;
        if (RSbusy_o !== 1'b0) $display("FAIL release_same_cycle got=%b exp=0", RSbusy_o); else n_pass++;
        n_total++;
        if (RSdata_o !== 32'hA5) $display("FAIL release_data got=%h exp=%h", RSdata_o, 32'hA5); else n_pass++;
        @(negedge clk_i);
        idle_inputs();
        #1;
        n_total++;
        if (RSbusy_o !== 1'b0) $display("FAIL release_after got=%b exp=0", RSbusy_o); else n_pass++;
        n_total++;
        if (RSdata_o !== 32'hA5) $display("FAIL release_stored got=%h exp=%h", RSdata_o, 32'hA5); else n_pass++;
    endtask

    task automatic test_back_to_back();
        @(negedge clk_i);
        RegWrite_i = 1'b1; RDaddr_i = 5'd3; RDdata_i = 32'h0000_0033;
        Rsv_i = 1'b1; RsvAddr_i = 5'd3;
        RSaddr_i = 5'd3; RTaddr_i = 5'd4;
        #1;
        n_total++;
        if (RSdata_o !== 32'h33) $display("FAIL same_addr_bypass got=%h exp=%h", RSdata_o, 32'h33); else n_pass++;
        @(negedge clk_i);
        idle_inputs();
        #1;
        n_total++;
        if (RSbusy_o !== 1'b1) $display("FAIL same_addr_rsv_wins got=%b exp=1", RSbusy_o); else n_pass++;
        n_total++;
        if (RSdata_o !== 32'h33) $display("FAIL same_addr_data got=%h exp=%h", RSdata_o, 32'h33); else n_pass++;
        @(negedge clk_i);
        RegWrite_i = 1'b1; RDaddr_i = 5'd3; RDdata_i = 32'h0000_0044;
        Rsv_i = 1'b1; RsvAddr_i = 5'd4;
        #1;
        n_total++;
        if ({RSbusy_o, RTbusy_o} !== 2'b00) $display("FAIL split_same_cycle got=%b exp=00", {RSbusy_o, RTbusy_o}); else n_pass++;
        @(negedge clk_i);
        idle_inputs();
        #1;
        n_total++;
        if ({RSbusy_o, RTbusy_o} !== 2'b01) $display("FAIL split_after got=%b exp=01", {RSbusy_o, RTbusy_o}); else n_pass++;
        n_total++;
        if (RSdata_o !== 32'h44) $display("FAIL split_data got=%h exp=%h", RSdata_o, 32'h44); else n_pass++;
    endtask

    task automatic test_async_reset();
        @(negedge clk_i);
        RegWrite_i = 1'b1; RDaddr_i = 5'd12; RDdata_i = 32'hFFFFFFFF;
        Rsv_i = 1'b1; RsvAddr_i = 5'd12;
        RTaddr_i = 5'd12; RSaddr_i = 5'd5;
        @(negedge clk_i);
        idle_inputs();
        #1;
        n_total++;
        if (RTdata_o !== 32'hFFFFFFFF || RTbusy_o !== 1'b1)
            $display("FAIL pre_reset_r12 got=%h/%b exp=ffffffff/1", RTdata_o, RTbusy_o);
        else n_pass++;
        #1 rst_n_i = 1'b0;
        #1;
        n_total++;
        if (RTdata_o !== 32'h0 || RTbusy_o !== 1'b0)
            $display("FAIL async_reset_r12 got=%h/%b exp=0/0", RTdata_o, RTbusy_o);
        else n_pass++;
        n_total++;
        if (RSdata_o !== 32'h0) $display("FAIL async_reset_r5 got=%h exp=%h", RSdata_o, 32'h0); else n_pass++;
        // Hold reset across an edge with a reserve pending; reset must win.
        Rsv_i = 1'b1; RsvAddr_i = 5'd12;
        @(negedge clk_i);
        idle_inputs();
        rst_n_i = 1'b1;
        #1;
        n_total++;
        if (RTbusy_o !== 1'b0) $display("FAIL reset_overrides_rsv got=%b exp=0", RTbusy_o); else n_pass++;
        @(negedge clk_i);
        Rsv_i = 1'b1; RsvAddr_i = 5'd12;
        @(negedge clk_i);
        idle_inputs();
        #1;
        n_total++;
        if (RTbusy_o !== 1'b1) $display("FAIL post_reset_rsv got=%b exp=1", RTbusy_o); else n_pass++;
    endtask

    initial begin
        RSaddr_i = '0;
        RTaddr_i = '0;
        idle_inputs();
        rst_n_i = 1'b0;
        #12 rst_n_i = 1'b1;
        test_reset();
        test_write_read();
        test_zero_reg();
        test_scoreboard();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised general-purpose register file for the pipelined CPU datapath, sitting between the decode stage (reads) and write-back (writes). It has two combinational read ports and one clock-edge write port, with a hardwired zero register and same-cycle write-to-read bypass. A per-register busy scoreboard lets decode see which registers have an in-flight producer. The block has an asynchronous active-low reset that clears every register and every busy bit.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W entries
- ZERO_REG, 1, when 1, entry 0 reads as 0, ignores writes and is never busy
- clk_i  in  1  clock; all state updates on rising edge
- rst_n_i  in  1  reset, asynchronous, active-low
- RSaddr_i  in  ADDR_W  read port S address
- RTaddr_i  in  ADDR_W  read port T address
- RDaddr_i  in  ADDR_W  write address
- RDdata_i  in  DATA_W  write data
- RegWrite_i  in  1  write enable; also clears the busy bit of RDaddr_i
- Rsv_i  in  1  reserve enable; sets the busy bit of RsvAddr_i
- RsvAddr_i  in  ADDR_W  reserve address
- RSdata_o  out  DATA_W  read data, port S
- RTdata_o  out  DATA_W  read data, port T
- RSbusy_o  out  1  busy status of RSaddr_i
- RTbusy_o  out  1  busy status of RTaddr_i

## Operation
- State: mem[0..2**ADDR_W-1] of DATA_W bits; busy[0..2**ADDR_W-1] of 1 bit.
- Write: on a rising edge with RegWrite_i=1, mem[RDaddr_i] <= RDdata_i. The write is suppressed when ZERO_REG=1 and RDaddr_i=0.
- Reserve: on a rising edge with Rsv_i=1, busy[RsvAddr_i] <= 1. Suppressed for address 0 when ZERO_REG=1.
- Release: on a rising edge with RegWrite_i=1, busy[RDaddr_i] <= 0.
- Same address, same edge, RegWrite_i=1 and Rsv_i=1: the reserve wins, so busy ends at 1 and mem takes RDdata_i (a newer producer has been issued).
- Different addresses, same edge: both the release and the reserve take effect.
- Read data (combinational), for each port X in {S,T}:
  - 0 if ZERO_REG=1 and Xaddr=0;
  - else RDdata_i if RegWrite_i=1 and RDaddr_i=Xaddr (bypass);
  - else mem[Xaddr].
- Busy (combinational), for each port:
  - 0 if ZERO_REG=1 and Xaddr=0;
  - else 0 if RegWrite_i=1, RDaddr_i=Xaddr and not (Rsv_i=1 and RsvAddr_i=Xaddr) (same-cycle release is visible);
  - else busy[Xaddr].
- Reserve does not bypass: a same-cycle reserve does not raise Xbusy_o until after the edge.
- Both read ports are fully independent and may address the same entry.
- No widening or truncation: all data paths are exactly DATA_W bits.

## Timing
- Reset: when rst_n_i=0, all mem entries = 0 and all busy bits = 0 immediately, without a clock edge. Outputs therefore become RSdata_o=RTdata_o=0 (apart from bypass driven by current inputs) and RSbusy_o=RTbusy_o=0.
- Reset asserted mid-operation overrides any same-cycle write or reserve. The first state update after deassertion happens on the next rising edge.
- Write latency: the value is visible on the read ports in the same cycle via bypass, and from mem from the cycle after the edge onward.
- Reserve latency: busy is visible starting the cycle after the edge.
- Only inputs feed the read outputs combinationally; there is no clock-to-output pipeline stage.
- Xdata_o and Xbusy_o are stable only after the address and write inputs settle; the consumer samples them at the next edge.

## Test plan
- Reset then read: pulse rst_n_i low with no clock, then read addresses 0, 7, 31 -> RSdata_o=RTdata_o=0 and busy=0 for all three.
- Write/read: write 0xDEADBEEF to r5. In the same cycle, RSaddr_i=5 gives 0xDEADBEEF (bypass). Next cycle, with RegWrite_i=0, RTaddr_i=5 still gives 0xDEADBEEF.
- Zero register: write 0x12345678 to r0 -> RSdata_o=0 both in the same cycle and afterwards. Rsv_i on r0 -> RSbusy_o stays 0.
- Scoreboard: reserve r9 -> the next cycle RSbusy_o=1. Write r9=0x0000_00A5 -> RSbusy_o=0 in the same cycle and RSdata_o=0xA5. The following cycle busy stays 0.
- Simultaneous reserve and write on r3 -> after the edge, busy[r3]=1 and mem[r3] holds the written data. Reserve r4 together with a write to r3 -> busy r4=1 and busy r3=0.
- Async reset mid-stream: write r12=0xFFFFFFFF, reserve r12, then drop rst_n_i between edges -> RTaddr_i=12 immediately gives 0 with RTbusy_o=0.
